// File: rtl/ps2_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx_if
// Purpose  : Command/status handshake and raw PS/2 pin levels for ps2_tx.
// Revision : 1.0
// ============================================================================
interface ps2_tx_if;
    logic       start;
    logic [7:0] data;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       error;

    modport master (
        output start, data, ps2_clk_i, ps2_dat_i,
        input  ps2_clk_oe, ps2_dat_oe, busy, done, error
    );

    modport slave (
        input  start, data, ps2_clk_i, ps2_dat_i,
        output ps2_clk_oe, ps2_dat_oe, busy, done, error
    );
endinterface
`default_nettype wire

// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Purpose  : Host-to-device PS/2 byte transmitter (inhibit, RTS, 11 bits, ACK).
//            Define PS2_TX_TIMEOUT_EN to abort a stalled frame after TIMEOUT.
// Revision : 1.0
// ============================================================================
module ps2_tx #(
    parameter int INHIBIT = 2500,
    parameter int SETUP   = 25,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 375000
) (
    input  wire logic clock,
    input  wire logic reset,
    ps2_tx_if.slave   bus
);
    localparam int TMR_W = $clog2(INHIBIT + SETUP + 1);
    localparam int FLT_W = $clog2(FILTER + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_BITS    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAITREL = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [1:0]       r_clk_sync;
    logic [1:0]       r_dat_sync;
    logic             r_clk_filt;
    logic             r_clk_filt_d;
    logic [FLT_W-1:0] r_flt_cnt;
    logic [TMR_W-1:0] r_tmr;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic             r_dat_drv;
    logic             w_fall;
    logic             w_to_hit;

    // Lines idle high, so synchronizers and filter reset to 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_sync   <= 2'b11;
            r_dat_sync   <= 2'b11;
            r_clk_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
            r_flt_cnt    <= '0;
        end else begin
            r_clk_sync   <= {r_clk_sync[0], bus.ps2_clk_i};
            r_dat_sync   <= {r_dat_sync[0], bus.ps2_dat_i};
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == FLT_W'(FILTER - 1)) begin
                r_clk_filt <= r_clk_sync[1];
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_to_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state == S_BITS || r_state == S_ACK) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_to_hit = (r_state == S_BITS || r_state == S_ACK) &&
                      (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign w_to_hit = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_INHIBIT;
            S_INHIBIT: if (r_tmr == TMR_W'(INHIBIT - 1)) w_next = S_REQ;
            S_REQ:     if (r_tmr == TMR_W'(SETUP - 1)) w_next = S_BITS;
            S_BITS:    if (w_fall && r_bit_cnt == 4'd9) w_next = S_ACK;
            S_ACK:     if (w_fall) w_next = r_dat_sync[1] ? S_ERR : S_WAITREL;
            S_WAITREL: if (r_clk_filt && r_dat_sync[1]) w_next = S_DONE;
            default:   w_next = S_IDLE;
        endcase
        if (w_to_hit) begin
            w_next = S_ERR;
        end
    end

    // Datapath: phase timer, bit counter and the data-line drive bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_dat_drv <= 1'b0;
        end else begin
            if ((r_state == S_INHIBIT || r_state == S_REQ) && w_next == r_state) begin
                r_tmr <= r_tmr + 1'b1;
            end else begin
                r_tmr <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shift  <= bus.data;
                        r_parity <= ~^bus.data;
                    end
                end
                S_REQ: begin
                    r_bit_cnt <= '0;
                    r_dat_drv <= 1'b1;
                end
                S_BITS: begin
                    if (w_fall) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt < 4'd8) begin
                            r_dat_drv <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end else if (r_bit_cnt == 4'd8) begin
                            r_dat_drv <= ~r_parity;
                        end else begin
                            r_dat_drv <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ps2_clk_oe = 1'b0;
        bus.ps2_dat_oe = 1'b0;
        bus.busy       = (r_state != S_IDLE);
        bus.done       = 1'b0;
        bus.error      = 1'b0;
        case (r_state)
            S_INHIBIT: bus.ps2_clk_oe = 1'b1;
            S_REQ: begin
                bus.ps2_clk_oe = 1'b1;
                bus.ps2_dat_oe = 1'b1;
            end
            S_BITS:    bus.ps2_dat_oe = r_dat_drv;
            S_DONE:    bus.done  = 1'b1;
            S_ERR:     bus.error = 1'b1;
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Purpose  : Directed bench for ps2_tx with a wired-AND PS/2 device model.
// Revision : 1.0
// ============================================================================
module tb_ps2_tx;
    localparam int INHIBIT = 2500;
    localparam int SETUP   = 25;
    localparam int FILTER  = 8;
    localparam int TIMEOUT = 3000;
    localparam int HALF    = 60;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic bfm_clk = 1'b1;
    logic bfm_dat = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done = 0;
    int   n_err  = 0;

    ps2_tx_if bus ();

    ps2_tx #(
        .INHIBIT (INHIBIT),
        .SETUP   (SETUP),
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.ps2_clk_i = bfm_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_dat_i = bfm_dat & ~bus.ps2_dat_oe;

    always #20 clock = ~clock;

    always @(negedge clock) begin
        if (bus.done)  n_done++;
        if (bus.error) n_err++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_start(input logic [7:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.data  = b;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Device model: measures the inhibit/RTS phase then clocks 11 bits
    task automatic bfm_frame(input logic ack_bit, input bit glitch, input int stop_after,
                             output logic [7:0] d, output logic par, output logic stp,
                             output int hi_cyc, output int inh_cyc);
        hi_cyc = 0; inh_cyc = 0; d = '0; par = 1'b0; stp = 1'b0;
        while (bus.ps2_clk_oe && hi_cyc < 10000) begin
            hi_cyc++;
            if (!bus.ps2_dat_oe) inh_cyc++;
            @(negedge clock);
        end
        repeat (20) @(negedge clock);
        for (int n = 1; n <= 11; n++) begin
            if (n == 11) bfm_dat = ack_bit;
            bfm_clk = 1'b0;
            repeat (HALF - 1) @(negedge clock);
            if (n <= 8)       d[n-1] = bus.ps2_dat_i;
            else if (n == 9)  par = bus.ps2_dat_i;
            else if (n == 10) stp = bus.ps2_dat_i;
            if (n == stop_after) return;
            @(negedge clock);
            bfm_clk = 1'b1;
            bfm_dat = 1'b1;
            for (int c = 0; c < HALF; c++) begin
                if (glitch && n == 3) bfm_clk = !(c >= 20 && c < 23);
                @(negedge clock);
            end
        end
    endtask

    logic [7:0] d;
    logic       par, stp;
    int         hi, inh, d0, e0, k;

    initial begin
        bus.start = 1'b0;
        bus.data  = 8'h00;
        repeat (3) @(negedge clock);
        check_val("rst_clk_oe", bus.ps2_clk_oe, 0);
        check_val("rst_dat_oe", bus.ps2_dat_oe, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done_err", {bus.done, bus.error}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // 0xED with ACK
        d0 = n_done; e0 = n_err;
        @(negedge clock);
        check_val("busy_before_start", bus.busy, 0);
        bus.start = 1'b1; bus.data = 8'hED;
        @(negedge clock);
        bus.start = 1'b0;
        check_val("busy_after_start", bus.busy, 1);
        check_val("clk_oe_after_start", bus.ps2_clk_oe, 1);
        bfm_frame(1'b0, 1'b0, 0, d, par, stp, hi, inh);
        repeat (5) @(negedge clock);
        check_val("ed_clk_oe_cycles", hi, INHIBIT + SETUP);
        check_val("ed_inhibit_cycles", inh, INHIBIT);
        check_val("ed_data", d, 8'hED);
        check_val("ed_parity", par, 1);
        check_val("ed_stop", stp, 1);
        check_val("ed_done", n_done - d0, 1);
        check_val("ed_error", n_err - e0, 0);
        check_val("ed_busy_after", bus.busy, 0);

        // 0x00 with NACK
        d0 = n_done; e0 = n_err;
        send_start(8'h00);
        bfm_frame(1'b1, 1'b0, 0, d, par, stp, hi, inh);
        repeat (5) @(negedge clock);
        check_val("nack_data", d, 8'h00);
        check_val("nack_parity", par, 1);
        check_val("nack_error", n_err - e0, 1);
        check_val("nack_done", n_done - d0, 0);
        check_val("nack_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);

        // second start while busy is ignored
        d0 = n_done;
        send_start(8'hF3);
        fork
            bfm_frame(1'b0, 1'b0, 0, d, par, stp, hi, inh);
            begin
                repeat (98) @(negedge clock);
                bus.start = 1'b1; bus.data = 8'h11;
                @(negedge clock);
                bus.start = 1'b0;
            end
        join
        repeat (5) @(negedge clock);
        check_val("ign_data", d, 8'hF3);
        check_val("ign_parity", par, 1);
        check_val("ign_clk_oe_cycles", hi, INHIBIT + SETUP);
        check_val("ign_done", n_done - d0, 1);

        // clock glitch ignored
        d0 = n_done;
        send_start(8'h5A);
        bfm_frame(1'b0, 1'b1, 0, d, par, stp, hi, inh);
        repeat (5) @(negedge clock);
        check_val("glitch_data", d, 8'h5A);
        check_val("glitch_parity", par, 1);
        check_val("glitch_done", n_done - d0, 1);

        // device never clocks
        e0 = n_err;
        send_start(8'hAA);
        k = 0;
        while (bus.ps2_clk_oe && k < 10000) begin k++; @(negedge clock); end
`ifdef PS2_TX_TIMEOUT_EN
        k = 0;
        while (!bus.error && k < 3 * TIMEOUT) begin @(negedge clock); k++; end
        check_val("to_cycles", k, TIMEOUT);
        check_val("to_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        @(negedge clock);
        check_val("to_busy_after", bus.busy, 0);
        check_val("to_error", n_err - e0, 1);
`else
        k = 0;
        repeat (2 * TIMEOUT) begin
            if (!bus.busy) k++;
            @(negedge clock);
        end
        check_val("noto_busy_low", k, 0);
        check_val("noto_error", n_err - e0, 0);
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
`endif

        // reset mid-frame after fall 5
        d0 = n_done; e0 = n_err;
        send_start(8'h3C);
        bfm_frame(1'b0, 1'b0, 5, d, par, stp, hi, inh);
        check_val("mid_busy_pre", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        check_val("mid_rst_busy", bus.busy, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        bfm_clk = 1'b1;
        repeat (30) @(negedge clock);
        check_val("mid_no_pulse", {n_done - d0, n_err - e0}, 0);

        send_start(8'hFF);
        bfm_frame(1'b0, 1'b0, 0, d, par, stp, hi, inh);
        repeat (5) @(negedge clock);
        check_val("post_data", d, 8'hFF);
        check_val("post_parity", par, 1);
        check_val("post_stop", stp, 1);
        check_val("post_done", n_done - d0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
